// File: rtl/alu_arbiter_if.sv
// Request/response bus between two requesters and the ALU arbiter.
// Operand fields are packed per requester: bits [32i+31:32i] and [3i+2:3i].
interface alu_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [5:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Flow: IDLE (grant/latch) -> EXEC (one cycle, capture result) -> RESP (hold until rsp_ready).
module alu_arbiter (
  input  logic               clk,
  input  logic               rst_n,
  alu_arbiter_if.slave       bus,
  output logic [31:0]        alu_inp1,
  output logic [31:0]        alu_inp2,
  output logic [2:0]         alu_sel,
  input  logic [31:0]        alu_out,
  input  logic               alu_zero,
  output logic               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        id_q, id_d;
  logic        last_q, last_d;
  logic [31:0] result_q, result_d;
  logic        zero_q, zero_d;

  logic        grant_id;
  logic [1:0]  ready;
  logic        accept;

  // Ready is gated by rst_n so it drops to zero the instant reset asserts.
  always_comb begin
    grant_id = 1'b0;
    case (bus.req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_q;
      default: grant_id = 1'b0;
    endcase
    ready = '0;
    if (rst_n && (state_q == S_IDLE) && (|bus.req_valid))
      ready[grant_id] = 1'b1;
  end

  assign accept = |(bus.req_valid & ready);

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    last_d   = last_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = grant_id ? bus.req_a[63:32] : bus.req_a[31:0];
          b_d     = grant_id ? bus.req_b[63:32] : bus.req_b[31:0];
          op_d    = grant_id ? bus.req_op[5:3]  : bus.req_op[2:0];
          id_d    = grant_id;
          last_d  = grant_id;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_out;
        zero_d   = alu_zero;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      last_q   <= last_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_zero   = zero_q;
  assign alu_inp1       = a_q;
  assign alu_inp2       = b_q;
  assign alu_sel        = op_q;
  assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a reference ALU attached to the shared ALU port.
module tb_alu_arbiter;
  logic        clk;
  logic        rst_n;
  logic [31:0] alu_inp1, alu_inp2, alu_out;
  logic [2:0]  alu_sel;
  logic        alu_zero;
  logic        busy;
  int          checks;
  int          errors;

  alu_arbiter_if bus_if ();

  alu_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .alu_inp1 (alu_inp1),
    .alu_inp2 (alu_inp2),
    .alu_sel  (alu_sel),
    .alu_out  (alu_out),
    .alu_zero (alu_zero),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: add, sub, and, or, xor, shl, shr, unsigned set-less-than.
  always_comb begin
    case (alu_sel)
      3'd0:    alu_out = alu_inp1 + alu_inp2;
      3'd1:    alu_out = alu_inp1 - alu_inp2;
      3'd2:    alu_out = alu_inp1 & alu_inp2;
      3'd3:    alu_out = alu_inp1 | alu_inp2;
      3'd4:    alu_out = alu_inp1 ^ alu_inp2;
      3'd5:    alu_out = alu_inp1 << alu_inp2[4:0];
      3'd6:    alu_out = alu_inp1 >> alu_inp2[4:0];
      default: alu_out = {31'd0, (alu_inp1 < alu_inp2)};
    endcase
    alu_zero = (alu_out == 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    bus_if.req_a[32*i +: 32] = a;
    bus_if.req_b[32*i +: 32] = b;
    bus_if.req_op[3*i +: 3]  = op;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.req_valid = 2'b11;
    bus_if.rsp_ready = 1'b0;
    bus_if.req_a = '0;
    bus_if.req_b = '0;
    bus_if.req_op = '0;
    tick();
    tick();
    checks++;
    if ({bus_if.req_ready, bus_if.rsp_valid, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b busy=%b, expected 00 0 0",
               bus_if.req_ready, bus_if.rsp_valid, busy);
    end
    checks++;
    if ({alu_inp1, alu_inp2, alu_sel, bus_if.rsp_result, bus_if.rsp_zero, bus_if.rsp_id} !== '0) begin
      errors++;
      $display("FAIL reset_data: got inp1=%h inp2=%h sel=%0d result=%h zero=%b id=%b, expected all 0",
               alu_inp1, alu_inp2, alu_sel, bus_if.rsp_result, bus_if.rsp_zero, bus_if.rsp_id);
    end
    bus_if.req_valid = 2'b00;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(0, 32'd5, 32'd3, 3'b000);
    bus_if.req_valid = 2'b01;
    #1;
    checks++;
    if (bus_if.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL single_ready: got %b expected 01", bus_if.req_ready);
    end
    tick();
    bus_if.req_valid = 2'b00;
    checks++;
    if ({busy, bus_if.rsp_valid, bus_if.req_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL single_exec: got busy=%b rsp_valid=%b ready=%b, expected 1 0 00",
               busy, bus_if.rsp_valid, bus_if.req_ready);
    end
    checks++;
    if ({alu_inp1, alu_inp2, alu_sel} !== {32'd5, 32'd3, 3'd0}) begin
      errors++;
      $display("FAIL single_alu_drive: got %0d %0d %0d expected 5 3 0", alu_inp1, alu_inp2, alu_sel);
    end
    tick();
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero} !== {1'b1, 1'b0, 32'd8, 1'b0}) begin
      errors++;
      $display("FAIL single_rsp: got valid=%b id=%b result=%0d zero=%b expected 1 0 8 0",
               bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    checks++;
    if ({busy, bus_if.rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_done: got busy=%b rsp_valid=%b expected 0 0", busy, bus_if.rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_req(0, 32'd7, 32'd7, 3'b001);
    set_req(1, 32'd2, 32'd9, 3'b111);
    bus_if.req_valid = 2'b11;
    bus_if.rsp_ready = 1'b0;
    #1;
    checks++;
    if (bus_if.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rr_first_grant: got %b expected 01", bus_if.req_ready);
    end
    tick();
    tick();
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero} !== {1'b1, 1'b0, 32'd0, 1'b1}) begin
      errors++;
      $display("FAIL rr_rsp0: got valid=%b id=%b result=%0d zero=%b expected 1 0 0 1",
               bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    checks++;
    if (bus_if.req_ready !== 2'b10) begin
      errors++;
      $display("FAIL rr_second_grant: got %b expected 10", bus_if.req_ready);
    end
    tick();
    tick();
    checks++;
    if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero} !== {1'b1, 1'b1, 32'd1, 1'b0}) begin
      errors++;
      $display("FAIL rr_rsp1: got valid=%b id=%b result=%0d zero=%b expected 1 1 1 0",
               bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
  endtask

  // Both requesters stay valid and rsp_ready stays high: 3-cycle issue interval.
  task automatic test_back_to_back();
    logic [31:0] exp_res [0:1];
    exp_res[0] = 32'd14;
    exp_res[1] = 32'd5;
    set_req(0, 32'd10, 32'd4, 3'b000);
    set_req(1, 32'd6, 32'd3, 3'b100);
    bus_if.req_valid = 2'b11;
    bus_if.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({busy, bus_if.req_ready} !== {1'b0, (k % 2 == 0) ? 2'b01 : 2'b10}) begin
        errors++;
        $display("FAIL b2b_grant[%0d]: got busy=%b ready=%b expected busy=0 ready=%b",
                 k, busy, bus_if.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
      checks++;
      if ({busy, bus_if.rsp_valid, bus_if.req_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL b2b_exec[%0d]: got busy=%b rsp_valid=%b ready=%b expected 1 0 00",
                 k, busy, bus_if.rsp_valid, bus_if.req_ready);
      end
      tick();
      checks++;
      if ({busy, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result} !==
          {1'b1, 1'b1, (k % 2 == 1), exp_res[k % 2]}) begin
        errors++;
        $display("FAIL b2b_rsp[%0d]: got busy=%b valid=%b id=%b result=%0d expected 1 1 %0d %0d",
                 k, busy, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, k % 2, exp_res[k % 2]);
      end
      tick();
    end
    bus_if.req_valid = 2'b00;
    bus_if.rsp_ready = 1'b0;
  endtask

  task automatic test_stall();
    set_req(0, 32'd1, 32'd1, 3'b001);
    bus_if.req_valid = 2'b01;
    tick();
    bus_if.req_valid = 2'b11;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero, bus_if.req_ready, busy} !==
          {1'b1, 1'b0, 32'd0, 1'b1, 2'b00, 1'b1}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b id=%b result=%0d zero=%b ready=%b busy=%b expected 1 0 0 1 00 1",
                 k, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero, bus_if.req_ready, busy);
      end
      tick();
    end
    bus_if.req_valid = 2'b00;
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
    checks++;
    if ({busy, bus_if.rsp_valid} !== 2'b00) begin
      errors++;
      $display("FAIL stall_release: got busy=%b rsp_valid=%b expected 0 0", busy, bus_if.rsp_valid);
    end
  endtask

  task automatic test_all_ops();
    logic [31:0] exp_res [0:7];
    exp_res[0] = 32'h0F5; exp_res[1] = 32'h0F1; exp_res[2] = 32'h002; exp_res[3] = 32'h0F3;
    exp_res[4] = 32'h0F1; exp_res[5] = 32'h3CC; exp_res[6] = 32'h03C; exp_res[7] = 32'h000;
    for (int k = 0; k < 8; k++) begin
      set_req(1, 32'h0F3, 32'd2, 3'(k));
      set_req(0, 32'hDEAD, 32'hBEEF, 3'(7 - k));
      bus_if.req_valid = 2'b10;
      #1;
      checks++;
      if (bus_if.req_ready !== 2'b10) begin
        errors++;
        $display("FAIL ops_ready[%0d]: got %b expected 10", k, bus_if.req_ready);
      end
      tick();
      bus_if.req_valid = 2'b00;
      checks++;
      if ({alu_inp1, alu_inp2, alu_sel} !== {32'h0F3, 32'd2, 3'(k)}) begin
        errors++;
        $display("FAIL ops_drive[%0d]: got inp1=%h inp2=%h sel=%0d expected f3 2 %0d", k, alu_inp1, alu_inp2, alu_sel, k);
      end
      tick();
      checks++;
      if ({bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero} !== {1'b1, exp_res[k], (exp_res[k] == 32'd0)}) begin
        errors++;
        $display("FAIL ops_result[%0d]: got id=%b result=%h zero=%b expected 1 %h %b",
                 k, bus_if.rsp_id, bus_if.rsp_result, bus_if.rsp_zero, exp_res[k], exp_res[k] == 32'd0);
      end
      bus_if.rsp_ready = 1'b1;
      tick();
      bus_if.rsp_ready = 1'b0;
    end
  endtask

  task automatic test_no_accept();
    bus_if.req_valid = 2'b01;
    bus_if.rsp_ready = 1'b1;
    #2;
    bus_if.req_valid = 2'b00;
    tick();
    tick();
    checks++;
    if ({busy, bus_if.rsp_valid, bus_if.req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL no_accept: got busy=%b rsp_valid=%b ready=%b expected 0 0 00", busy, bus_if.rsp_valid, bus_if.req_ready);
    end
    bus_if.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_exec();
    logic seen_valid;
    set_req(1, 32'd40, 32'd2, 3'b000);
    set_req(0, 32'd9, 32'd4, 3'b001);
    bus_if.req_valid = 2'b10;
    tick();
    bus_if.req_valid = 2'b11;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_if.req_ready, bus_if.rsp_valid, busy, alu_inp1, alu_inp2, alu_sel, bus_if.rsp_result,
         bus_if.rsp_zero, bus_if.rsp_id} !== '0) begin
      errors++;
      $display("FAIL reset_exec_async: got ready=%b valid=%b busy=%b inp1=%h inp2=%h sel=%0d result=%h zero=%b id=%b expected all 0",
               bus_if.req_ready, bus_if.rsp_valid, busy, alu_inp1, alu_inp2, alu_sel,
               bus_if.rsp_result, bus_if.rsp_zero, bus_if.rsp_id);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus_if.req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_exec_grant: got %b expected 01", bus_if.req_ready);
    end
    seen_valid = 1'b0;
    tick();
    bus_if.req_valid = 2'b00;
    seen_valid = bus_if.rsp_valid;
    tick();
    checks++;
    if ({seen_valid, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result} !== {1'b0, 1'b1, 1'b0, 32'd5}) begin
      errors++;
      $display("FAIL reset_exec_rsp: got early_valid=%b valid=%b id=%b result=%0d expected 0 1 0 5",
               seen_valid, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_result);
    end
    bus_if.rsp_ready = 1'b1;
    tick();
    bus_if.rsp_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_all_ops();
    test_no_accept();
    test_reset_exec();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
